// File: rtl/cache_req_ctrl.sv
// cache_req_ctrl: request sequencer in front of an 8-set cache.
// Each accepted reference walks IDLE -> SEARCH -> UPDATE -> RESP. The set
// is searched, the aligned buddy pair is pushed into it, and the set's
// registered hit flag is reported back. The result is one request every
// four cycles.
// Optional build macro: CACHE_REQ_CTRL_STATS_EN adds saturating hit, miss
// and request counters. When it is undefined, the counter outputs are tied
// to zero.
module cache_req_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  output logic             req_ready,
  output logic [7:0]       set_sel,
  output logic [26:0]      set_tag,
  output logic             set_state,
  output logic             set_mem_write,
  output logic [63:0]      set_write_data,
  input  logic [7:0]       set_hit_vec,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] req_count
);

  typedef enum logic [1:0] {IDLE, SEARCH, UPDATE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  idx;
  logic        resp_hit_q;
  logic        accept;

  assign idx    = addr_q[4:2];
  assign accept = req_valid && req_ready;

  // State register; reset forces IDLE without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-state set commands. Each state lasts exactly one
  // cycle, except IDLE, which waits for a request.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    set_sel       = 8'h00;
    set_state     = 1'b0;
    set_mem_write = 1'b0;
    resp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = SEARCH;
      end
      SEARCH: begin
        set_sel = 8'b1 << idx;
        state_d = UPDATE;
      end
      UPDATE: begin
        set_sel       = 8'b1 << idx;
        set_state     = 1'b1;
        set_mem_write = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the reference on accept. Set-side outputs come only from this
  // copy, so req_addr may change freely while a request is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         addr_q <= 32'h0;
    else if (accept) addr_q <= req_addr;
  end

  // Sample only the selected set's hit flag on the edge that ends UPDATE.
  // The value holds until the next request reaches that point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    resp_hit_q <= 1'b0;
    else if (state_q == UPDATE) resp_hit_q <= set_hit_vec[idx];
  end

  assign resp_hit = resp_hit_q;
  assign set_tag  = addr_q[31:5];

  // Buddy pair: the two word addresses that differ only in bit 2.
  // This output is gated by reset because OR-ing in bit 2 would otherwise
  // show a nonzero value out of the cleared address while reset is held.
  assign set_write_data = rst ? 64'h0 : {addr_q | 32'h4, addr_q & ~32'h4};

`ifdef CACHE_REQ_CTRL_STATS_EN
  logic [CNT_W-1:0] hit_q, miss_q, req_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Count each completed request once, during its RESP cycle.
  // An aborted request never reaches RESP and is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
      req_q  <= '0;
    end else if (state_q == RESP) begin
      req_q <= sat_inc(req_q);
      if (resp_hit_q) hit_q  <= sat_inc(hit_q);
      else            miss_q <= sat_inc(miss_q);
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign req_count  = req_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign req_count  = '0;
`endif

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench for cache_req_ctrl. It uses a narrow counter width so
// that saturation is reachable. Expected counter values follow the
// CACHE_REQ_CTRL_STATS_EN build setting.
module tb_cache_req_ctrl;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;
`ifdef CACHE_REQ_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [31:0]      req_addr;
  logic             req_ready;
  logic [7:0]       set_sel;
  logic [26:0]      set_tag;
  logic             set_state;
  logic             set_mem_write;
  logic [63:0]      set_write_data;
  logic [7:0]       set_hit_vec;
  logic             resp_valid;
  logic             resp_hit;
  logic [CNT_W-1:0] hit_count, miss_count, req_count;

  int n_chk  = 0;
  int n_fail = 0;
  int e_hit  = 0, e_miss = 0, e_req = 0;

  cache_req_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .set_sel(set_sel), .set_tag(set_tag),
    .set_state(set_state), .set_mem_write(set_mem_write),
    .set_write_data(set_write_data), .set_hit_vec(set_hit_vec),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .hit_count(hit_count),
    .miss_count(miss_count), .req_count(req_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v == CMAX) ? v : v + 1;
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, "_hitc"},  64'(hit_count),  STATS ? 64'(e_hit)  : 64'h0);
    chk({tag, "_missc"}, 64'(miss_count), STATS ? 64'(e_miss) : 64'h0);
    chk({tag, "_reqc"},  64'(req_count),  STATS ? 64'(e_req)  : 64'h0);
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready),     64'h1);
    chk({tag, "_sel"},   64'(set_sel),       64'h0);
    chk({tag, "_tag"},   64'(set_tag),       64'h0);
    chk({tag, "_st"},    64'(set_state),     64'h0);
    chk({tag, "_mw"},    64'(set_mem_write), 64'h0);
    chk({tag, "_wd"},    set_write_data,     64'h0);
    chk({tag, "_rv"},    64'(resp_valid),    64'h0);
    chk({tag, "_rh"},    64'(resp_hit),      64'h0);
    chk_cnt(tag);
  endtask

  // One full request with hand-computed set outputs and result.
  task automatic run_req(input string nm, input logic [31:0] a, input logic [7:0] hv,
                         input logic [7:0] esel, input logic [26:0] etag,
                         input logic [63:0] ewd, input logic ehit);
    req_valid = 1'b1; req_addr = a; set_hit_vec = hv;
    tick();                                   // E0: accept
    req_valid = 1'b0; req_addr = 32'hDEAD_BEEF;
    chk({nm, "_s_sel"},   64'(set_sel),       64'(esel));
    chk({nm, "_s_tag"},   64'(set_tag),       64'(etag));
    chk({nm, "_s_st"},    64'(set_state),     64'h0);
    chk({nm, "_s_mw"},    64'(set_mem_write), 64'h0);
    chk({nm, "_s_wd"},    set_write_data,     ewd);
    chk({nm, "_s_rdy"},   64'(req_ready),     64'h0);
    chk({nm, "_s_rv"},    64'(resp_valid),    64'h0);
    tick();                                   // E1: UPDATE
    chk({nm, "_u_sel"},   64'(set_sel),       64'(esel));
    chk({nm, "_u_st"},    64'(set_state),     64'h1);
    chk({nm, "_u_mw"},    64'(set_mem_write), 64'h1);
    chk({nm, "_u_rv"},    64'(resp_valid),    64'h0);
    tick();                                   // E2: RESP
    chk({nm, "_r_rv"},    64'(resp_valid),    64'h1);
    chk({nm, "_r_hit"},   64'(resp_hit),      64'(ehit));
    chk({nm, "_r_sel"},   64'(set_sel),       64'h0);
    chk({nm, "_r_rdy"},   64'(req_ready),     64'h0);
    tick();                                   // E3: IDLE
    e_req = sat(e_req);
    if (ehit) e_hit = sat(e_hit); else e_miss = sat(e_miss);
    chk({nm, "_i_rv"},    64'(resp_valid),    64'h0);
    chk({nm, "_i_rdy"},   64'(req_ready),     64'h1);
    chk({nm, "_i_hold"},  64'(resp_hit),      64'(ehit));
    chk({nm, "_i_tag"},   64'(set_tag),       64'(etag));
    chk_cnt(nm);
  endtask

  initial begin
    int acc_n, rv_n;
    int acc[3];
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; set_hit_vec = 8'h00;
    @(negedge clk);
    chk_rst_outs("rst0");
    rst = 1'b0;

    run_req("hit24",  32'h0000_0024, 8'h02, 8'h02, 27'h1,       64'h0000_0024_0000_0020, 1'b1);
    run_req("miss24", 32'h0000_0024, 8'hFD, 8'h02, 27'h1,       64'h0000_0024_0000_0020, 1'b0);
    run_req("allone", 32'hFFFF_FFFF, 8'h80, 8'h80, 27'h7FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    run_req("zero",   32'h0000_0000, 8'hFE, 8'h01, 27'h0,       64'h0000_0004_0000_0000, 1'b0);
    run_req("mixed",  32'h1234_5678, 8'h40, 8'h40, 27'h091_A2B3, 64'h1234_567C_1234_5678, 1'b1);

    // Back-to-back: req_valid held for 12 edges.
    acc_n = 0; rv_n = 0;
    req_valid = 1'b1; req_addr = 32'h0000_0024; set_hit_vec = 8'h02;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid) rv_n++;
      if (req_ready) begin
        if (acc_n < 3) acc[acc_n] = i;
        acc_n++;
      end
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
    chk("b2b_accepts", 64'(acc_n), 64'd3);
    chk("b2b_acc0", 64'(acc[0]), 64'd0);
    chk("b2b_acc1", 64'(acc[1]), 64'd4);
    chk("b2b_acc2", 64'(acc[2]), 64'd8);
    chk("b2b_resps", 64'(rv_n), 64'd3);
    for (int k = 0; k < 3; k++) begin
      e_req = sat(e_req); e_hit = sat(e_hit);
    end
    chk_cnt("b2b");

    // Reset during UPDATE aborts the request.
    req_valid = 1'b1; req_addr = 32'h0000_0024; set_hit_vec = 8'h02;
    tick();
    req_valid = 1'b0;
    tick();
    chk("abort_in_update", 64'(set_mem_write), 64'h1);
    #2 rst = 1'b1;
    #1;
    e_hit = 0; e_miss = 0; e_req = 0;
    chk_rst_outs("abort");
    tick();
    chk_rst_outs("abort_hold");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_rv", 64'(resp_valid), 64'h0);
    end
    chk_cnt("abort_post");

    // Misses to saturate the narrow counters.
    for (int k = 0; k < 8; k++)
      run_req("satmiss", 32'h0000_0000, 8'hFE, 8'h01, 27'h0, 64'h0000_0004_0000_0000, 1'b0);
    chk("sat_miss_model", 64'(e_miss), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_req_ctrl.md
CACHE_REQ_CTRL -- requirements
Module: cache_req_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of the hit, miss and request statistics counters.
REQ-002 Port: clk  input  1  system clock; all state updates on posedge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  input  1  reference request present.
REQ-005 Port: req_addr  input  32  byte address of a 4-byte reference.
REQ-006 Port: req_ready  output  1  controller can accept a request.
REQ-007 Port: set_sel  output  8  one-hot select of the target cache set.
REQ-008 Port: set_tag  output  27  tag presented to the selected set.
REQ-009 Port: set_state  output  1  set FSM command: 0 = search, 1 = update.
REQ-010 Port: set_mem_write  output  1  push strobe to the selected set.
REQ-011 Port: set_write_data  output  64  line data (reference plus buddy) pushed to the set.
REQ-012 Port: set_hit_vec  input  8  registered hit flag from each of the 8 sets.
REQ-013 Port: resp_valid  output  1  one-cycle completion pulse.
REQ-014 Port: resp_hit  output  1  result of the completed request: 1 = hit, 0 = miss.
REQ-015 Port: hit_count, miss_count, req_count  output  CNT_W each  statistics counters.

Function
REQ-016 Address split SHALL be fixed: offset = addr[1:0] (ignored), index = addr[4:2], tag = addr[31:5].
REQ-017 FSM states SHALL be IDLE, SEARCH, UPDATE and RESP, with transitions IDLE->SEARCH on accept, SEARCH->UPDATE, UPDATE->RESP and RESP->IDLE, each unconditional after one cycle.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a posedge where req_valid && req_ready.
REQ-019 On accept, req_addr SHALL be captured into an internal register; set outputs SHALL derive only from the captured address.
REQ-020 Requests presented while req_ready=0 SHALL be ignored and are not queued.
REQ-021 In SEARCH: set_sel = 1<<index, set_state = 0, set_mem_write = 0.
REQ-022 In UPDATE: set_sel = 1<<index, set_state = 1, set_mem_write = 1.
REQ-023 In IDLE and RESP: set_sel = 0, set_state = 0, set_mem_write = 0.
REQ-024 set_tag SHALL equal the captured tag in all states.
REQ-025 set_write_data SHALL equal {captured_addr | 32'h4, captured_addr & ~32'h4} in all states; these are the aligned buddy pair.
REQ-026 At the posedge ending UPDATE, set_hit_vec[index] SHALL be sampled into resp_hit; the other bits of set_hit_vec are ignored.
REQ-027 resp_valid SHALL be 1 for exactly the RESP cycle; resp_hit SHALL hold its value until the next UPDATE sample.
REQ-028 Latency: with accept at edge E0, SEARCH runs E0-E1, UPDATE runs E1-E2, resp_valid is high E2-E3, and req_ready is high again from E3. Throughput is one request per 4 cycles.
REQ-029 Back-to-back requests (req_valid held high) SHALL be accepted at the first edge in IDLE, i.e. every 4th edge.

Reset
REQ-030 While rst=1, the FSM SHALL be forced to IDLE immediately, regardless of clk.
REQ-031 While rst=1, all outputs SHALL be 0 except req_ready, which is 1.
REQ-032 While rst=1, the captured address and all counters SHALL be cleared.
REQ-033 Reset asserted mid-request (SEARCH, UPDATE or RESP) SHALL abort the request with no resp_valid pulse and no counter update.
REQ-034 After rst deasserts, a request MAY be accepted at the first posedge.

Configuration
REQ-035 Macro CACHE_REQ_CTRL_STATS_EN, defined: in RESP, req_count increments by 1, and hit_count or miss_count increments by 1 according to resp_hit.
REQ-036 Macro CACHE_REQ_CTRL_STATS_EN, defined: each counter saturates at all-ones and does not wrap.
REQ-037 Macro CACHE_REQ_CTRL_STATS_EN, undefined: the counter registers SHALL be omitted and hit_count, miss_count and req_count tied to 0.

Verification
REQ-038 Reset then req_addr=32'h0000_0024 accepted -> set_sel=8'h02 and set_tag=27'h1 in SEARCH; set_write_data=64'h0000_0024_0000_0020; resp_valid exactly 3 edges after accept.
REQ-039 set_hit_vec[1]=1 during UPDATE with the same address -> resp_hit=1; hit_count=1 and miss_count=0 with STATS_EN defined.
REQ-040 set_hit_vec=8'hFD (selected bit 0) -> resp_hit=0 and miss_count increments, confirming non-selected bits are ignored.
REQ-041 req_valid held high for 12 cycles -> exactly 3 accepts, at edges 0, 4 and 8; req_count=3.
REQ-042 rst pulsed during UPDATE -> outputs zero immediately, no resp_valid, counters 0, req_ready=1.
REQ-043 Build without CACHE_REQ_CTRL_STATS_EN and 5 requests -> all counters remain 0 while resp behaviour is unchanged.
